axi_stream_width_down: RTL and testbench

//  Downsizing AXI-stream width converter: accepts IN_BYTS-wide beats on an if_axi_stream

---
 rtl/axi_stream_width_down_if.sv | 20 ++
 rtl/axi_stream_width_down.sv | 112 +++++++++++
 tb/tb_axi_stream_width_down.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_width_down_if.sv
// Generic AXI-stream bundle: data beat with packet framing (sop/eop), error flag,
// byte modulus on the final beat (0 = all bytes valid) and a sideband control field.
interface if_axi_stream #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8
);
  localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

  logic                  val;
  logic                  rdy;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [MOD_BITS-1:0]   mod;
  logic [CTL_BITS-1:0]   ctl;
  logic [DAT_BYTS*8-1:0] dat;

  modport source (output val, sop, eop, err, mod, ctl, dat, input rdy);
  modport sink   (input val, sop, eop, err, mod, ctl, dat, output rdy);
endinterface

// File: rtl/axi_stream_width_down.sv
// Downsizing AXI-stream converter: holds one wide input beat and replays it as
// RATIO (or fewer, for a short eop beat) narrow output beats with full throughput.
module axi_stream_width_down #(
  parameter int IN_BYTS  = 16,
  parameter int OUT_BYTS = 8,
  parameter int CTL_BITS = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  if_axi_stream.sink   i_axi,
  if_axi_stream.source o_axi
);
  localparam int RATIO     = IN_BYTS / OUT_BYTS;
  localparam int OUT_BITS  = OUT_BYTS * 8;
  localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int NB_W      = $clog2(IN_BYTS + 1);
  localparam int OUT_MOD_W = (OUT_BYTS > 1) ? $clog2(OUT_BYTS) : 1;

  generate
    if (RATIO < 2 || RATIO * OUT_BYTS != IN_BYTS) begin : g_bad_ratio
      $fatal(1, "axi_stream_width_down: IN_BYTS must be an integer multiple >= 2 of OUT_BYTS");
    end
  endgenerate

  typedef enum logic {EMPTY, SEND} state_t;

  state_t                         state;
  logic [RATIO-1:0][OUT_BITS-1:0] held_dat;
  logic                           held_eop;
  logic                           held_err;
  logic [NB_W-1:0]                nbytes;
  logic [CNT_W-1:0]               last;
  logic [CNT_W-1:0]               cnt;

  logic                           slice_done;
  logic                           beat_done;
  logic                           take;
  logic [NB_W-1:0]                in_nbytes;
  logic [CNT_W-1:0]               in_last;
  logic                           in_single_eop;
  logic [CNT_W-1:0]               next_cnt;
  logic                           next_eop;

  function automatic logic [OUT_MOD_W-1:0] tail_mod(input logic [NB_W-1:0] nb);
    return OUT_MOD_W'(int'(nb) % OUT_BYTS);
  endfunction

  // Input is accepted only when the held beat is free or its final slice leaves this cycle.
  assign slice_done = o_axi.val && o_axi.rdy;
  assign beat_done  = slice_done && (cnt == last);
  assign i_axi.rdy  = !i_rst && (state == EMPTY || beat_done);
  assign take       = i_axi.val && i_axi.rdy;

  always_comb begin
    in_nbytes = NB_W'(IN_BYTS);
    if (i_axi.eop && i_axi.mod != '0) in_nbytes = NB_W'(i_axi.mod);
    in_last       = CNT_W'((int'(in_nbytes) + OUT_BYTS - 1) / OUT_BYTS - 1);
    in_single_eop = i_axi.eop && (in_last == '0);
  end

  assign next_cnt = cnt + CNT_W'(1);
  assign next_eop = held_eop && (next_cnt == last);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= EMPTY;
      held_dat  <= '0;
      held_eop  <= 1'b0;
      held_err  <= 1'b0;
      nbytes    <= '0;
      last      <= '0;
      cnt       <= '0;
      o_axi.val <= 1'b0;
      o_axi.sop <= 1'b0;
      o_axi.eop <= 1'b0;
      o_axi.err <= 1'b0;
      o_axi.mod <= '0;
      o_axi.ctl <= '0;
      o_axi.dat <= '0;
    end else if (take) begin
      // Slice 0 goes straight to the output register, so no bubble between beats.
      state     <= SEND;
      held_dat  <= i_axi.dat;
      held_eop  <= i_axi.eop;
      held_err  <= i_axi.err;
      nbytes    <= in_nbytes;
      last      <= in_last;
      cnt       <= '0;
      o_axi.val <= 1'b1;
      o_axi.sop <= i_axi.sop;
      o_axi.eop <= in_single_eop;
      o_axi.err <= i_axi.err && in_single_eop;
      o_axi.mod <= in_single_eop ? tail_mod(in_nbytes) : '0;
      o_axi.ctl <= i_axi.ctl;
      o_axi.dat <= i_axi.dat[OUT_BITS-1:0];
    end else if (beat_done) begin
      state     <= EMPTY;
      o_axi.val <= 1'b0;
      o_axi.sop <= 1'b0;
      o_axi.eop <= 1'b0;
      o_axi.err <= 1'b0;
      o_axi.mod <= '0;
    end else if (slice_done) begin
      cnt       <= next_cnt;
      o_axi.sop <= 1'b0;
      o_axi.eop <= next_eop;
      o_axi.err <= held_err && next_eop;
      o_axi.mod <= next_eop ? tail_mod(nbytes) : '0;
      o_axi.dat <= held_dat[next_cnt];
    end
  end
endmodule

// File: tb/tb_axi_stream_width_down.sv
// Self-checking bench for axi_stream_width_down (16 -> 8 bytes): directed framing
// scenarios plus a randomized packet stream against a byte-level reference model.
module tb_axi_stream_width_down;
  localparam int IN_BYTS  = 16;
  localparam int OUT_BYTS = 8;
  localparam int CTL_BITS = 8;

  typedef struct packed {
    logic [63:0] dat;
    logic [7:0]  ctl;
    logic        sop;
    logic        eop;
    logic        err;
    logic [2:0]  mod;
  } obeat_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     total = 0;
  int     bad = 0;
  obeat_t got[$];

  if_axi_stream #(.DAT_BYTS(IN_BYTS), .CTL_BITS(CTL_BITS)) in_bus ();
  if_axi_stream #(.DAT_BYTS(OUT_BYTS), .CTL_BITS(CTL_BITS)) out_bus ();

  axi_stream_width_down #(
    .IN_BYTS(IN_BYTS),
    .OUT_BYTS(OUT_BYTS),
    .CTL_BITS(CTL_BITS)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_axi(in_bus),
    .o_axi(out_bus)
  );

  always #5 clk = ~clk;

  // Output transfers are recorded mid-cycle; the handshake completes at the next posedge.
  always @(negedge clk) begin
    if (out_bus.val === 1'b1 && out_bus.rdy === 1'b1 && rst === 1'b0)
      got.push_back({out_bus.dat, out_bus.ctl, out_bus.sop, out_bus.eop, out_bus.err, out_bus.mod});
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic put_beat(input logic [127:0] dat, input logic [7:0] ctl,
                          input logic sop, input logic eop, input logic err,
                          input logic [3:0] mod);
    int n;
    n = 0;
    in_bus.val = 1'b1;
    in_bus.dat = dat;
    in_bus.ctl = ctl;
    in_bus.sop = sop;
    in_bus.eop = eop;
    in_bus.err = err;
    in_bus.mod = mod;
    #1;
    while (in_bus.rdy !== 1'b1 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("[TB] FAIL put_beat_timeout: in rdy=%b, required 1 within 200 cycles", in_bus.rdy);
      in_bus.val = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_bus.val = 1'b0;
    end
  endtask

  task automatic wait_drain(input int want);
    int n;
    n = 0;
    while (got.size() < want && n < 500) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_bus.val = 1'b1;
    in_bus.dat = rand128();
    in_bus.ctl = 8'hff;
    in_bus.sop = 1'b1;
    in_bus.eop = 1'b1;
    in_bus.err = 1'b1;
    in_bus.mod = 4'd0;
    out_bus.rdy = 1'b1;
    repeat (3) tick();
    total++;
    if (in_bus.rdy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_in_rdy: got %b, required 0", in_bus.rdy);
    end
    total++;
    if (out_bus.val !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_out_val: got %b, required 0", out_bus.val);
    end
    total++;
    if ({out_bus.sop, out_bus.eop, out_bus.err, out_bus.mod, out_bus.ctl, out_bus.dat} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_out_fields: got sop=%b eop=%b err=%b mod=%h ctl=%h dat=%h, required all 0",
               out_bus.sop, out_bus.eop, out_bus.err, out_bus.mod, out_bus.ctl, out_bus.dat);
    end
    in_bus.val = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (in_bus.rdy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_rdy: got %b, required 1", in_bus.rdy);
    end
    tick();
  endtask

  task automatic test_single_beat();
    logic [127:0] d;
    logic [7:0]   c;
    obeat_t       exp[$];
    d = rand128();
    c = 8'($urandom);
    out_bus.rdy = 1'b1;
    got.delete();
    put_beat(d, c, 1'b1, 1'b1, 1'b1, 4'd0);
    total++;
    if (out_bus.val !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_latency: out val=%b one cycle after accept, required 1", out_bus.val);
    end
    tick();
    tick();
    total++;
    if (out_bus.val !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_idle: out val=%b after last slice, required 0", out_bus.val);
    end
    exp.push_back('{dat: d[63:0],   ctl: c, sop: 1'b1, eop: 1'b0, err: 1'b0, mod: 3'd0});
    exp.push_back('{dat: d[127:64], ctl: c, sop: 1'b0, eop: 1'b1, err: 1'b1, mod: 3'd0});
    total++;
    if (got.size() !== exp.size()) begin
      bad++;
      $display("[TB] FAIL single_count: got %0d beats, required %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        total++;
        if (got[i] !== exp[i]) begin
          bad++;
          $display("[TB] FAIL single_beat[%0d]: got %h, required %h", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_partial_packet();
    logic [127:0] b1, b2;
    logic [7:0]   c1, c2;
    obeat_t       exp[$];
    b1 = rand128();
    b2 = rand128();
    c1 = 8'($urandom);
    c2 = 8'($urandom);
    out_bus.rdy = 1'b1;
    got.delete();
    put_beat(b1, c1, 1'b1, 1'b0, 1'b1, 4'd7);
    put_beat(b2, c2, 1'b0, 1'b1, 1'b1, 4'd4);
    wait_drain(3);
    repeat (3) tick();
    exp.push_back('{dat: b1[63:0],   ctl: c1, sop: 1'b1, eop: 1'b0, err: 1'b0, mod: 3'd0});
    exp.push_back('{dat: b1[127:64], ctl: c1, sop: 1'b0, eop: 1'b0, err: 1'b0, mod: 3'd0});
    exp.push_back('{dat: b2[63:0],   ctl: c2, sop: 1'b0, eop: 1'b1, err: 1'b1, mod: 3'd4});
    total++;
    if (got.size() !== exp.size()) begin
      bad++;
      $display("[TB] FAIL partial_count: got %0d beats, required %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        total++;
        if (got[i] !== exp[i]) begin
          bad++;
          $display("[TB] FAIL partial_beat[%0d]: got %h, required %h", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_odd_mods();
    logic [127:0] d1, d2, d3;
    logic [7:0]   c1, c2, c3;
    obeat_t       exp[$];
    d1 = rand128();
    d2 = rand128();
    d3 = rand128();
    c1 = 8'($urandom);
    c2 = 8'($urandom);
    c3 = 8'($urandom);
    out_bus.rdy = 1'b1;
    got.delete();
    put_beat(d1, c1, 1'b1, 1'b1, 1'b0, 4'd9);
    put_beat(d2, c2, 1'b1, 1'b1, 1'b1, 4'd3);
    put_beat(d3, c3, 1'b1, 1'b1, 1'b0, 4'd8);
    wait_drain(4);
    repeat (4) tick();
    exp.push_back('{dat: d1[63:0],   ctl: c1, sop: 1'b1, eop: 1'b0, err: 1'b0, mod: 3'd0});
    exp.push_back('{dat: d1[127:64], ctl: c1, sop: 1'b0, eop: 1'b1, err: 1'b0, mod: 3'd1});
    exp.push_back('{dat: d2[63:0],   ctl: c2, sop: 1'b1, eop: 1'b1, err: 1'b1, mod: 3'd3});
    exp.push_back('{dat: d3[63:0],   ctl: c3, sop: 1'b1, eop: 1'b1, err: 1'b0, mod: 3'd0});
    total++;
    if (got.size() !== exp.size()) begin
      bad++;
      $display("[TB] FAIL odd_mod_count: got %0d beats, required %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        total++;
        if (got[i] !== exp[i]) begin
          bad++;
          $display("[TB] FAIL odd_mod_beat[%0d]: got %h, required %h", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] dq[4];
    logic [7:0]   c;
    logic         r[9];
    logic         v[9];
    obeat_t       exp[$];
    c = 8'($urandom);
    for (int i = 0; i < 4; i++) dq[i] = rand128();
    out_bus.rdy = 1'b1;
    got.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) put_beat(dq[i], c, i == 0, i == 3, 1'b0, 4'd0);
      end
      begin
        for (int i = 0; i < 9; i++) begin
          @(negedge clk);
          r[i] = in_bus.rdy;
          v[i] = out_bus.val;
        end
      end
    join
    wait_drain(8);
    repeat (2) tick();
    for (int i = 0; i < 9; i++) begin
      total++;
      if (r[i] !== 1'(i % 2 == 0)) begin
        bad++;
        $display("[TB] FAIL b2b_in_rdy[%0d]: got %b, required %b", i, r[i], 1'(i % 2 == 0));
      end
    end
    for (int i = 1; i < 9; i++) begin
      total++;
      if (v[i] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_out_val[%0d]: got %b, required 1", i, v[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp.push_back('{dat: dq[i][63:0],   ctl: c, sop: 1'(i == 0), eop: 1'b0,     err: 1'b0, mod: 3'd0});
      exp.push_back('{dat: dq[i][127:64], ctl: c, sop: 1'b0,     eop: 1'(i == 3), err: 1'b0, mod: 3'd0});
    end
    total++;
    if (got.size() !== exp.size()) begin
      bad++;
      $display("[TB] FAIL b2b_count: got %0d beats, required %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        total++;
        if (got[i] !== exp[i]) begin
          bad++;
          $display("[TB] FAIL b2b_beat[%0d]: got %h, required %h", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [127:0] b1, b3;
    logic [7:0]   c1, c3;
    obeat_t       exp[$];
    b1 = rand128();
    b3 = rand128();
    c1 = 8'($urandom);
    c3 = 8'($urandom);
    out_bus.rdy = 1'b1;
    got.delete();
    put_beat(b1, c1, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    rst = 1'b1;
    #1;
    total++;
    if (in_bus.rdy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_in_rdy: got %b during reset, required 0", in_bus.rdy);
    end
    tick();
    total++;
    if (out_bus.val !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_out_val: got %b after reset edge, required 0", out_bus.val);
    end
    rst = 1'b0;
    got.delete();
    put_beat(b3, c3, 1'b1, 1'b1, 1'b0, 4'd12);
    wait_drain(2);
    repeat (3) tick();
    exp.push_back('{dat: b3[63:0],   ctl: c3, sop: 1'b1, eop: 1'b0, err: 1'b0, mod: 3'd0});
    exp.push_back('{dat: b3[127:64], ctl: c3, sop: 1'b0, eop: 1'b1, err: 1'b0, mod: 3'd4});
    total++;
    if (got.size() !== exp.size()) begin
      bad++;
      $display("[TB] FAIL midrst_count: got %0d beats, required %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        total++;
        if (got[i] !== exp[i]) begin
          bad++;
          $display("[TB] FAIL midrst_beat[%0d]: got %h, required %h", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_random_stream();
    obeat_t exp[$];
    int     lens[$];
    logic   drv_done;
    int     acc;
    int     pk;
    drv_done = 1'b0;
    got.delete();
    fork
      begin
        for (int p = 0; p < 500; p++) begin
          int len;
          int nbeats;
          len = $urandom_range(1, 200);
          lens.push_back(len);
          nbeats = (len + IN_BYTS - 1) / IN_BYTS;
          for (int b = 0; b < nbeats; b++) begin
            logic [127:0] d;
            logic [7:0]   c;
            logic         e, s, l;
            logic [3:0]   m;
            int           nb, ns;
            d = rand128();
            c = 8'($urandom);
            e = 1'($urandom);
            s = (b == 0);
            l = (b == nbeats - 1);
            m = l ? 4'(len % IN_BYTS) : 4'($urandom);
            // Reference: the beat carries nb bytes, emitted low-first in 8-byte pieces.
            nb = (l && m != 0) ? int'(m) : IN_BYTS;
            ns = (nb + OUT_BYTS - 1) / OUT_BYTS;
            for (int k = 0; k < ns; k++) begin
              obeat_t o;
              o.dat = d[k*64 +: 64];
              o.ctl = c;
              o.sop = s && (k == 0);
              o.eop = l && (k == ns - 1);
              o.err = e && o.eop;
              o.mod = o.eop ? 3'(nb % OUT_BYTS) : 3'd0;
              exp.push_back(o);
            end
            if ($urandom_range(0, 3) == 0) tick();
            put_beat(d, c, s, l, e, m);
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          out_bus.rdy = 1'($urandom);
          tick();
        end
        out_bus.rdy = 1'b1;
      end
    join
    wait_drain(exp.size());
    repeat (3) tick();
    total++;
    if (got.size() !== exp.size()) begin
      bad++;
      $display("[TB] FAIL stream_count: got %0d beats, required %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        total++;
        if (got[i] !== exp[i]) begin
          bad++;
          $display("[TB] FAIL stream_beat[%0d]: got %h, required %h", i, got[i], exp[i]);
        end
      end
    end
    acc = 0;
    pk = 0;
    for (int i = 0; i < got.size(); i++) begin
      acc += (got[i].eop && got[i].mod != 0) ? int'(got[i].mod) : OUT_BYTS;
      if (got[i].eop) begin
        if (pk < lens.size()) begin
          total++;
          if (acc !== lens[pk]) begin
            bad++;
            $display("[TB] FAIL stream_pkt_len[%0d]: got %0d bytes, required %0d", pk, acc, lens[pk]);
          end
        end
        pk++;
        acc = 0;
      end
    end
    total++;
    if (pk !== lens.size()) begin
      bad++;
      $display("[TB] FAIL stream_pkt_count: got %0d packets, required %0d", pk, lens.size());
    end
  endtask

  initial begin
    in_bus.val = 1'b0;
    in_bus.dat = '0;
    in_bus.ctl = '0;
    in_bus.sop = 1'b0;
    in_bus.eop = 1'b0;
    in_bus.err = 1'b0;
    in_bus.mod = '0;
    out_bus.rdy = 1'b0;
    test_reset();
    test_single_beat();
    test_partial_packet();
    test_odd_mods();
    test_back_to_back();
    test_reset_mid_packet();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
